iob_native2wb_bridge: RTL and testbench
=======================================

# iob_native2wb_bridge

Responder on the IOb native bus (valid/address/wdata/wstrb → rdata/ready) that converts each native access into a single classic Wishbone cycle. It lets native-bus initiators (CPU, testbenches) program Wishbone peripherals such as the ethmac register bank. It has one outstanding transaction at a time, a bounded wait for the slave, and a one-cycle `ready` pulse that carries read data back to the initiator.

## Interface
- `ADDR_W`, 12: native word-address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT_W`, 8: width of the slave-response timeout counter. Limit is 2^TIMEOUT_W−1 cycles.

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge.
- `arst_n_i`  in  1  asynchronous, active-low reset.
- `valid`  in  1  request strobe; sampled only in IDLE.
- `address`  in  ADDR_W  word address.
- `wdata`  in  DATA_W  write data.
- `wstrb`  in  DATA_W/8  byte enables; nonzero = write, zero = read.
- `rdata`  out  DATA_W  read data; meaningful only while `ready`=1.
- `ready`  out  1  one-cycle completion pulse.
- `err_o`  out  1  pulses together with `ready` when the access ended by `wb_err_i` or by timeout.
- `busy_o`  out  1  high from acceptance until the cycle after `ready`.
- `wb_adr_o`  out  ADDR_W+2  byte address, {address, 2'b00}.
- `wb_dat_o`  out  DATA_W  write data.
- `wb_sel_o`  out  DATA_W/8  byte select. Equals wstrb on writes and all ones on reads.
- `wb_we_o`, `wb_cyc_o`, `wb_stb_o`  out  1 each.
- `wb_dat_i`  in  DATA_W; `wb_ack_i`, `wb_err_i`  in  1 each.

## Operation
- States: IDLE → WAIT → RESP → IDLE.
- **IDLE**
  - `valid`=1 at a rising edge latches address, wdata, wstrb and the write flag into the `wb_*` output registers.
  - The same edge sets `wb_cyc_o`=`wb_stb_o`=1, clears the timeout counter and moves to WAIT.
- **WAIT**
  - The counter increments every cycle.
  - On a rising edge with `wb_err_i`=1: clear cyc/stb/we, set rdata=0, go to RESP with the error flag set.
  - Otherwise, on an edge with `wb_ack_i`=1: clear cyc/stb/we, set rdata=`wb_dat_i` for reads or 0 for writes, go to RESP.
  - Otherwise, when the counter equals 2^TIMEOUT_W−1: abort the cycle the same way as err (rdata=0, error flag set), go to RESP.
- **RESP**: `ready`=1 for exactly one cycle, and `err_o` equals the error flag. Next edge returns to IDLE and clears `rdata` and `err_o`.
- Priority in one cycle: err > ack > timeout.
- `valid` asserted in WAIT or RESP is ignored. It is not queued, and the initiator must wait for `ready`.
- `wb_adr_o`, `wb_dat_o` and `wb_sel_o` hold their last values after a cycle ends. Slaves must qualify them with `wb_stb_o`.
- Reset (`arst_n_i`=0), including mid-transaction:
  - All outputs go to 0 immediately: `ready`, `rdata`, `err_o`, `busy_o` and all `wb_*` outputs.
  - State → IDLE, counter → 0.
  - The in-flight access is dropped with no `ready`.

## Timing
- Cycle n: `valid`=1 in IDLE. `wb_cyc_o`/`wb_stb_o` are high from cycle n+1.
- If the slave acks in cycle n+k (k≥1), cyc/stb drop in cycle n+k+1 and `ready` is high in cycle n+k+1.
- Minimum valid→ready latency is 2 cycles.
- `busy_o` is high in cycles n+1 … n+k+1.
- The earliest next accepted `valid` is in cycle n+k+2.
- Timeout: with no response, `ready`/`err_o` pulse in cycle n+2^TIMEOUT_W+1. With TIMEOUT_W=8 that is n+257.
- All outputs are registered. There is no combinational path from `wb_*` inputs to native outputs.

## Test plan
- **Write:** valid=1, address=0x000, wdata=0x0000A080, wstrb=0xF, slave acks 1 cycle after stb.
  - wb_adr_o=0x000, wb_we_o=1, wb_sel_o=0xF, wb_dat_o=0x0000A080.
  - ready pulses 1 cycle at n+2 with rdata=0 and err_o=0.
- **Read:** address=0x001, wstrb=0, slave returns 0x12345678 after 3 wait cycles.
  - wb_adr_o=0x004, wb_we_o=0, wb_sel_o=0xF.
  - ready at n+5 with rdata=0x12345678.
- **Error and priority:** the slave asserts wb_err_i and wb_ack_i in the same cycle.
  - ready=1, err_o=1, rdata=0, cyc dropped.
  - A subsequent clean read succeeds.
- **Timeout:** TIMEOUT_W=4, slave never responds.
  - ready=1 and err_o=1 at n+17, rdata=0, wb_cyc_o=0.
  - The next request is accepted normally.
- **Ignored request:** a second valid with wdata=0xFFFFFFFF during WAIT.
  - Exactly one Wishbone cycle, carrying the first wdata.
  - Exactly one ready pulse.
- **Reset mid-transaction:** assert arst_n_i=0 during WAIT.
  - All outputs 0 immediately; no ready pulse follows.
  - After release, a write of 0x0000A480 completes with 2-cycle latency.

Source files
------------

// File: rtl/iob_native2wb_bridge_if.sv
// Signal bundle between a native-bus initiator, the bridge and a Wishbone peripheral.
// The slave modport is the bridge's view; master is the initiator/peripheral side.
interface iob_native2wb_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;
    logic                  err_o;
    logic                  busy_o;

    logic [ADDR_W+1:0]     wb_adr_o;
    logic [DATA_W-1:0]     wb_dat_o;
    logic [DATA_W/8-1:0]   wb_sel_o;
    logic                  wb_we_o;
    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic [DATA_W-1:0]     wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;

    modport slave (
        input  valid, address, wdata, wstrb, wb_dat_i, wb_ack_i, wb_err_i,
        output rdata, ready, err_o, busy_o,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );

    modport master (
        output valid, address, wdata, wstrb, wb_dat_i, wb_ack_i, wb_err_i,
        input  rdata, ready, err_o, busy_o,
               wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o
    );
endinterface

// File: rtl/iob_native2wb_bridge.sv
// Converts each IOb native access into one classic Wishbone cycle, with one access
// in flight, a bounded wait for the slave and a single-cycle ready pulse.
module iob_native2wb_bridge #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT_W = 8
) (
    input logic clk_i,
    input logic arst_n_i,
    iob_native2wb_bridge_if.slave bus
);
    localparam int SEL_W = DATA_W / 8;
    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [TIMEOUT_W-1:0] r_count;
    logic                 w_accept;
    logic                 w_done;
    logic                 w_fail;

    logic [DATA_W-1:0]    r_rdata;
    logic                 r_ready;
    logic                 r_err;
    logic                 r_busy;
    logic [ADDR_W+1:0]    r_adr;
    logic [DATA_W-1:0]    r_dat;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_we;
    logic                 r_cyc;
    logic                 r_stb;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) r_state <= S_IDLE;
        else           r_state <= w_state_next;
    end

    // Slave error beats ack, and ack beats an expiring timeout in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        w_fail       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.wb_err_i) begin
                    w_done = 1'b1;
                    w_fail = 1'b1;
                end else if (bus.wb_ack_i) begin
                    w_done = 1'b1;
                end else if (r_count == CNT_MAX) begin
                    w_done = 1'b1;
                    w_fail = 1'b1;
                end
                if (w_done) w_state_next = S_RESP;
            end
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_count <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_adr   <= '0;
            r_dat   <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (w_accept) begin
                r_adr   <= {bus.address, 2'b00};
                r_dat   <= bus.wdata;
                r_sel   <= (|bus.wstrb) ? bus.wstrb : {SEL_W{1'b1}};
                r_we    <= |bus.wstrb;
                r_cyc   <= 1'b1;
                r_stb   <= 1'b1;
                r_busy  <= 1'b1;
                r_count <= '0;
            end
            if (r_state == S_WAIT) begin
                if (w_done) begin
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    r_err   <= w_fail;
                    r_rdata <= (!w_fail && !r_we) ? bus.wb_dat_i : '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
            if (r_state == S_RESP) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.rdata    = r_rdata;
    assign bus.ready    = r_ready;
    assign bus.err_o    = r_err;
    assign bus.busy_o   = r_busy;
    assign bus.wb_adr_o = r_adr;
    assign bus.wb_dat_o = r_dat;
    assign bus.wb_sel_o = r_sel;
    assign bus.wb_we_o  = r_we;
    assign bus.wb_cyc_o = r_cyc;
    assign bus.wb_stb_o = r_stb;
endmodule

// File: tb/tb_iob_native2wb_bridge.sv
// Self-checking bench for iob_native2wb_bridge: directed vector table, reset-in-flight
// sequence and randomized accesses compared against a transaction-level model.
module tb_iob_native2wb_bridge;
    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int TIMEOUT_W = 4;
    localparam int TO_LAT    = (1 << TIMEOUT_W) + 1;

    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          kind;
        int          delay;
        logic [31:0] slvData;
        bit          inject;
        int          expLat;
        logic [31:0] expRdata;
        logic        expErr;
        logic [13:0] expAdr;
        logic [3:0]  expSel;
        logic        expWe;
    } vec_t;

    logic clk;
    logic rstN;
    int   vectors;
    int   miscompares;
    vec_t table_q[$];

    iob_native2wb_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    iob_native2wb_bridge #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_W(TIMEOUT_W)
    ) dut (
        .clk_i(clk),
        .arst_n_i(rstN),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: latency, data and flags derived from the response kind.
    function automatic vec_t modelExpect(input vec_t v);
        vec_t r;
        r = v;
        r.expLat   = (v.kind == K_NONE) ? TO_LAT : v.delay + 1;
        r.expErr   = (v.kind != K_ACK);
        r.expRdata = (v.kind == K_ACK && v.wstrb == 4'h0) ? v.slvData : 32'h0;
        r.expAdr   = 14'(v.addr * 4);
        r.expSel   = (v.wstrb == 4'h0) ? 4'hF : v.wstrb;
        r.expWe    = (v.wstrb != 4'h0);
        return r;
    endfunction

    function automatic vec_t mk(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                input int k, input int d, input logic [31:0] sd, input bit inj,
                                input int lat, input logic [31:0] rd, input logic er,
                                input logic [13:0] adr, input logic [3:0] sel, input logic we);
        vec_t v;
        v.addr = a; v.wdata = wd; v.wstrb = ws; v.kind = k; v.delay = d; v.slvData = sd;
        v.inject = inj; v.expLat = lat; v.expRdata = rd; v.expErr = er;
        v.expAdr = adr; v.expSel = sel; v.expWe = we;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v, input string tag);
        int          firstReady;
        int          readyCount;
        int          cycStarts;
        int          lastC;
        bit          datHeld;
        bit          respond;
        logic        prevCyc;
        logic [31:0] rdAt;
        logic        errAt;
        logic        cycAt;
        logic        busyAt;
        firstReady = 0; readyCount = 0; cycStarts = 0; datHeld = 1'b1; prevCyc = 1'b0;
        rdAt = '0; errAt = 1'b0; cycAt = 1'b0; busyAt = 1'b0;
        lastC = v.expLat + 3;
        @(negedge clk);
        bus.valid = 1'b1; bus.address = v.addr; bus.wdata = v.wdata; bus.wstrb = v.wstrb;
        for (int c = 1; c <= lastC; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checkOutput({tag, " cyc"}, 64'(bus.wb_cyc_o), 64'd1);
                checkOutput({tag, " stb"}, 64'(bus.wb_stb_o), 64'd1);
                checkOutput({tag, " adr"}, 64'(bus.wb_adr_o), 64'(v.expAdr));
                checkOutput({tag, " sel"}, 64'(bus.wb_sel_o), 64'(v.expSel));
                checkOutput({tag, " we"}, 64'(bus.wb_we_o), 64'(v.expWe));
                checkOutput({tag, " busy"}, 64'(bus.busy_o), 64'd1);
                bus.valid = v.inject;
                if (v.inject) begin
                    bus.wdata = 32'hFFFF_FFFF; bus.address = ~v.addr; bus.wstrb = 4'hF;
                end
            end else begin
                bus.valid = 1'b0;
            end
            if (bus.wb_cyc_o && !prevCyc) cycStarts++;
            prevCyc = bus.wb_cyc_o;
            if (bus.wb_dat_o !== v.wdata) datHeld = 1'b0;
            if (bus.ready) begin
                readyCount++;
                if (firstReady == 0) begin
                    firstReady = c; rdAt = bus.rdata; errAt = bus.err_o;
                    cycAt = bus.wb_cyc_o; busyAt = bus.busy_o;
                end
            end
            if (c == v.expLat + 1) begin
                checkOutput({tag, " busy after"}, 64'(bus.busy_o), 64'd0);
                checkOutput({tag, " rdata after"}, 64'(bus.rdata), 64'd0);
                checkOutput({tag, " err after"}, 64'(bus.err_o), 64'd0);
            end
            respond = (v.kind != K_NONE) && (c == v.delay);
            bus.wb_ack_i = respond && (v.kind == K_ACK || v.kind == K_BOTH);
            bus.wb_err_i = respond && (v.kind == K_ERR || v.kind == K_BOTH);
            bus.wb_dat_i = respond ? v.slvData : 32'hBAD0_BAD0;
        end
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
        checkOutput({tag, " latency"}, 64'(firstReady), 64'(v.expLat));
        checkOutput({tag, " rdata"}, 64'(rdAt), 64'(v.expRdata));
        checkOutput({tag, " err"}, 64'(errAt), 64'(v.expErr));
        checkOutput({tag, " cyc at ready"}, 64'(cycAt), 64'd0);
        checkOutput({tag, " busy at ready"}, 64'(busyAt), 64'd1);
        checkOutput({tag, " ready pulses"}, 64'(readyCount), 64'd1);
        checkOutput({tag, " wb cycles"}, 64'(cycStarts), 64'd1);
        checkOutput({tag, " dat held"}, 64'(datHeld), 64'd1);
    endtask

    // Main sequence: reset, directed table, reset during WAIT, then random traffic.
    initial begin
        vec_t v;
        int   readyCount;
        int   r;
        vectors = 0; miscompares = 0;
        rstN = 1'b0;
        bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;

        table_q.push_back(mk(12'h000, 32'h0000_A080, 4'hF, K_ACK, 1, 32'h5555_5555, 0, 2, 32'h0, 0, 14'h0000, 4'hF, 1));
        table_q.push_back(mk(12'h001, 32'h0, 4'h0, K_ACK, 4, 32'h1234_5678, 0, 5, 32'h1234_5678, 0, 14'h0004, 4'hF, 0));
        table_q.push_back(mk(12'h003, 32'h0, 4'h0, K_BOTH, 2, 32'hDEAD_BEEF, 0, 3, 32'h0, 1, 14'h000C, 4'hF, 0));
        table_q.push_back(mk(12'h010, 32'h0, 4'h0, K_ACK, 1, 32'hCAFE_F00D, 0, 2, 32'hCAFE_F00D, 0, 14'h0040, 4'hF, 0));
        table_q.push_back(mk(12'h020, 32'h0, 4'h0, K_NONE, 0, 32'h0, 0, 17, 32'h0, 1, 14'h0080, 4'hF, 0));
        table_q.push_back(mk(12'hFFF, 32'h1122_3344, 4'h5, K_ACK, 3, 32'h7777_7777, 0, 4, 32'h0, 0, 14'h3FFC, 4'h5, 1));
        table_q.push_back(mk(12'h007, 32'h0000_0055, 4'hF, K_ACK, 3, 32'h0, 1, 4, 32'h0, 0, 14'h001C, 4'hF, 1));
        table_q.push_back(mk(12'h008, 32'hA5A5_0000, 4'hC, K_ERR, 2, 32'h0, 0, 3, 32'h0, 1, 14'h0020, 4'hC, 1));
        table_q.push_back(mk(12'h009, 32'h0, 4'h0, K_ERR, 1, 32'h9999_9999, 0, 2, 32'h0, 1, 14'h0024, 4'hF, 0));
        table_q.push_back(mk(12'h00A, 32'h0, 4'h0, K_ACK, 16, 32'h0BAD_F00D, 0, 17, 32'h0BAD_F00D, 0, 14'h0028, 4'hF, 0));
        table_q.push_back(mk(12'h00B, 32'h0, 4'h0, K_ACK, 15, 32'h1357_9BDF, 0, 16, 32'h1357_9BDF, 0, 14'h002C, 4'hF, 0));

        repeat (3) @(negedge clk);
        checkOutput("reset ready", 64'(bus.ready), 64'd0);
        checkOutput("reset busy", 64'(bus.busy_o), 64'd0);
        checkOutput("reset wb outs", 64'({bus.wb_adr_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o}), 64'd0);
        rstN = 1'b1;
        @(negedge clk);

        foreach (table_q[i]) applyStimulus(table_q[i], $sformatf("vec%0d", i));

        @(negedge clk);
        bus.valid = 1'b1; bus.address = 12'h005; bus.wdata = 32'h0; bus.wstrb = 4'h0;
        @(negedge clk);
        bus.valid = 1'b0;
        checkOutput("rst seq cyc", 64'(bus.wb_cyc_o), 64'd1);
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("rst seq wb outs", 64'({bus.wb_adr_o, bus.wb_dat_o, bus.wb_sel_o, bus.wb_we_o, bus.wb_cyc_o, bus.wb_stb_o}), 64'd0);
        checkOutput("rst seq native outs", 64'({bus.rdata, bus.ready, bus.err_o, bus.busy_o}), 64'd0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        bus.wb_ack_i = 1'b1; bus.wb_dat_i = 32'h4444_4444;
        readyCount = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.ready) readyCount++;
        end
        bus.wb_ack_i = 1'b0;
        checkOutput("rst seq no ready", 64'(readyCount), 64'd0);
        applyStimulus(mk(12'h002, 32'h0000_A480, 4'hF, K_ACK, 1, 32'h0, 0, 2, 32'h0, 0, 14'h0008, 4'hF, 1), "post-reset write");

        for (int i = 0; i < 40; i++) begin
            v.addr = 12'($urandom);
            v.wdata = $urandom;
            v.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            r = $urandom_range(0, 9);
            v.kind = (r == 6) ? K_ERR : (r == 7) ? K_BOTH : (r == 8) ? K_NONE : K_ACK;
            v.delay = $urandom_range(1, 16);
            v.slvData = $urandom;
            v.inject = ($urandom_range(0, 7) == 0);
            applyStimulus(modelExpect(v), $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
